hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage processor; companion to the forwarding logic.
- Resolves the hazards forwarding cannot cover:
  - load-use stalls
  - taken-branch flushes
  - memory-busy freezes
  - HLT halt/resume
- Drives the write enables and bubble/flush controls of the PC and pipeline registers.

Parameters:
REG_ADDR_W, 3, register-address width (8 GPRs)
FLUSH_CYCLES, 2, bubbles inserted after a taken branch resolved in EX; legal range 1..3
CNT_W, 16, width of the performance counters (optional feature only)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs  input  REG_ADDR_W  ID source field rs
id_rd  input  REG_ADDR_W  ID field rd (also a source for ALU ops)
id_use_rs  input  1  ID instruction reads rs
id_use_rd  input  1  ID instruction reads rd
ex_mem_read  input  1  EX instruction is a load
ex_dest  input  REG_ADDR_W  EX load destination register
branch_taken_ex  input  1  branch resolved taken in EX
halt_ex  input  1  HLT instruction in EX
resume  input  1  restart request from the halted state
mem_busy  input  1  data/instruction memory not ready
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID register enable
id_ex_bubble  output  1  load NOP into ID/EX
if_id_flush  output  1  clear IF/ID to NOP
pipe_hold  output  1  freeze ID/EX, EX/MEM and MEM/WB
halted  output  1  processor halted
state  output  2  FSM state: 0 RUN, 1 FLUSH, 2 HALT, 3 MEM_WAIT

Behaviour:
- Reset (async, any state):
  - state=RUN, flush counter=0.
  - While reset is high, outputs are forced regardless of inputs: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=0, pipe_hold=0, halted=0.
- Load-use hazard, combinational:
  - lu = id_valid & ex_mem_read & ((id_use_rs & id_rs==ex_dest) | (id_use_rd & id_rd==ex_dest)).
- Event priority in RUN, highest first: halt_ex > branch_taken_ex > mem_busy > lu.
- RUN:
  - No events: pc_write=1, if_id_write=1, all other controls 0.
  - lu only: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly 1 cycle; stay in RUN. The next cycle EX holds the bubble, so lu clears and forwarding from MEM covers the load.
  - branch_taken_ex: if_id_flush=1, id_ex_bubble=1, pc_write=1 (target loaded). Go to FLUSH with counter=FLUSH_CYCLES-1. If FLUSH_CYCLES==1, stay in RUN.
  - branch_taken_ex together with lu: the flush wins; no stall is issued.
  - halt_ex: pc_write=0, if_id_write=0, id_ex_bubble=1. Go to HALT. Older instructions in MEM/WB keep draining.
  - mem_busy: all enables 0, pipe_hold=1. Go to MEM_WAIT.
- FLUSH:
  - Outputs: if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - Counter decrements each cycle; go to RUN when it reaches 0.
  - mem_busy during FLUSH: pipe_hold=1, pc_write=0, counter holds, state stays FLUSH.
  - halt_ex and lu are ignored (EX holds bubbles).
- HALT:
  - Outputs: halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_hold=0.
  - resume=1: go to RUN next cycle; halted drops in that cycle.
  - All other inputs are ignored.
- MEM_WAIT:
  - Outputs: pipe_hold=1, pc_write=0, if_id_write=0, no bubble.
  - Return to RUN the first cycle mem_busy=0; hazards are re-evaluated in that RUN cycle.
  - branch_taken_ex/halt_ex arriving while held are acted on after the return to RUN, because the inputs persist when frozen.
- Unused state encoding: go to RUN.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs lu_stall_cnt, flush_cnt and mem_wait_cnt, each CNT_W bits.
  - lu_stall_cnt increments per load-use stall cycle; flush_cnt per if_id_flush cycle; mem_wait_cnt per pipe_hold cycle.
  - Counters saturate at all-ones and are cleared by reset.
- Undefined: the ports and counters are absent; there is no functional change otherwise.

Decomposition:
- Shared package pipeline_pkg holds:
  - state encodings RUN/FLUSH/HALT/MEM_WAIT
  - REG_ADDR_W
  - the NOP encoding used by the bubble/flush logic
- One natural sub-module: hazard_detect, the combinational lu compare.
- FSM and output decode stay in hazard_controller.

Test Plan:
- Load r2 in EX (ex_mem_read=1, ex_dest=2), ID ADD with rs=2, id_use_rs=1 -> 1 cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle normal RUN.
- branch_taken_ex=1 with FLUSH_CYCLES=2 -> if_id_flush=1 for 2 consecutive cycles, state RUN->FLUSH->RUN; lu asserted simultaneously -> no stall.
- halt_ex=1 -> halted=1 from the next cycle, pc_write=0 held for 10 cycles; resume=1 -> halted=0, pc_write=1 the cycle after.
- mem_busy=1 for 3 cycles in RUN -> pipe_hold=1 for 3 cycles, state=3; the FLUSH counter is frozen when mem_busy hits mid-flush.
- reset asserted mid-FLUSH (counter=1) -> immediate state=RUN, pc_write=1, if_id_flush=0; after release, normal operation.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 1 branch (FLUSH_CYCLES=2) -> lu_stall_cnt=2, flush_cnt=2; saturation check with CNT_W=2.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: controller state encodings, register-address
// width and the instruction word loaded by bubble/flush logic.
package pipeline_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned INSTR_W    = 16;

  // All-zero word decodes as NOP in the pipeline registers.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_HALT     = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: ID/EX hazard sources in, pipeline enables out.
// HAZARD_PERF_CNT_EN adds the performance counter outputs.
interface hazard_controller_if
`ifdef HAZARD_PERF_CNT_EN
  #(parameter int unsigned CNT_W = 16)
`endif
  ;
  import pipeline_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_use_rs;
  logic                  id_use_rd;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  branch_taken_ex;
  logic                  halt_ex;
  logic                  resume;
  logic                  mem_busy;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_bubble;
  logic                  if_id_flush;
  logic                  pipe_hold;
  logic                  halted;
  logic [1:0]            state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]      lu_stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  logic [CNT_W-1:0]      mem_wait_cnt;
`endif

  // Pipeline side: drives hazard sources, consumes enables.
  modport master (
    output id_valid, id_rs, id_rd, id_use_rs, id_use_rd,
    output ex_mem_read, ex_dest, branch_taken_ex, halt_ex, resume, mem_busy,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold,
    input  halted, state
`ifdef HAZARD_PERF_CNT_EN
    , input lu_stall_cnt, flush_cnt, mem_wait_cnt
`endif
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs, id_rd, id_use_rs, id_use_rd,
    input  ex_mem_read, ex_dest, branch_taken_ex, halt_ex, resume, mem_busy,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold,
    output halted, state
`ifdef HAZARD_PERF_CNT_EN
    , output lu_stall_cnt, flush_cnt, mem_wait_cnt
`endif
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX load destination.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs,
  input  logic                  id_use_rd,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  lu_c
);

  // rd counts as a source for ALU ops that read it.
  always_comb begin
    lu_c = id_valid & ex_mem_read &
           ((id_use_rs & (id_rs == ex_dest)) | (id_use_rd & (id_rd == ex_dest)));
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes,
// memory-busy freezes and HLT halt/resume for the 5-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds saturating performance counters.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  hazard_controller_if.slave hc
);

  localparam int unsigned FC_W = 2;

  // Reject out-of-range configuration at elaboration.
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || CNT_W < 1) begin : g_bad_param
    $error("hazard_controller: FLUSH_CYCLES must be 1..3 and CNT_W >= 1");
  end

  state_e          state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            lu_c;
  logic            lu_stall_c;
  logic            pc_write_c, if_id_write_c, id_ex_bubble_c;
  logic            if_id_flush_c, pipe_hold_c, halted_c;

  hazard_detect u_detect (
    .id_valid    (hc.id_valid),
    .id_rs       (hc.id_rs),
    .id_rd       (hc.id_rd),
    .id_use_rs   (hc.id_use_rs),
    .id_use_rd   (hc.id_use_rd),
    .ex_mem_read (hc.ex_mem_read),
    .ex_dest     (hc.ex_dest),
    .lu_c        (lu_c)
  );

  // State and flush-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state and control decode; MEM_WAIT with memory ready decodes as RUN.
  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    lu_stall_c      = 1'b0;
    pc_write_c      = 1'b1;
    if_id_write_c   = 1'b1;
    id_ex_bubble_c  = 1'b0;
    if_id_flush_c   = 1'b0;
    pipe_hold_c     = 1'b0;
    halted_c        = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (state_q == ST_MEM_WAIT && hc.mem_busy) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            pipe_hold_c   = 1'b1;
          end else if (hc.halt_ex) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
            state_d        = ST_HALT;
          end else if (hc.branch_taken_ex) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            if (FLUSH_CYCLES == 1) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_FLUSH;
              fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
            end
          end else if (hc.mem_busy) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            pipe_hold_c   = 1'b1;
            state_d       = ST_MEM_WAIT;
          end else begin
            lu_stall_c = lu_c;
            state_d    = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          if (hc.mem_busy) begin
            pc_write_c  = 1'b0;
            pipe_hold_c = 1'b1;
          end else if (fcnt_q <= FC_W'(1)) begin
            fcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            fcnt_d = fcnt_q - FC_W'(1);
          end
        end
        ST_HALT: begin
          halted_c       = 1'b1;
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          if (hc.resume) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
      if (lu_stall_c) begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b1;
      end
    end
  end

  assign hc.pc_write     = pc_write_c;
  assign hc.if_id_write  = if_id_write_c;
  assign hc.id_ex_bubble = id_ex_bubble_c;
  assign hc.if_id_flush  = if_id_flush_c;
  assign hc.pipe_hold    = pipe_hold_c;
  assign hc.halted       = halted_c;
  assign hc.state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, flush_cnt_q, mw_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_cnt_q    <= '0;
      flush_cnt_q <= '0;
      mw_cnt_q    <= '0;
    end else begin
      if (lu_stall_c && lu_cnt_q != '1)       lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
      if (if_id_flush_c && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (pipe_hold_c && mw_cnt_q != '1)      mw_cnt_q    <= mw_cnt_q + CNT_W'(1);
    end
  end

  assign hc.lu_stall_cnt = lu_cnt_q;
  assign hc.flush_cnt    = flush_cnt_q;
  assign hc.mem_wait_cnt = mw_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (FLUSH_CYCLES=2). With
// HAZARD_PERF_CNT_EN the counters are built with CNT_W=2 to reach saturation.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  hazard_controller_if #(.CNT_W(2)) hif ();
  hazard_controller #(.FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .hc(hif)
  );
`else
  hazard_controller_if hif ();
  hazard_controller #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .hc(hif)
  );
`endif

  // Control vector: {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_hold, halted, state[1:0]}
  localparam logic [7:0] C_RUN    = 8'b1100_0000;
  localparam logic [7:0] C_STALL  = 8'b0010_0000;
  localparam logic [7:0] C_BRANCH = 8'b1011_0000;
  localparam logic [7:0] C_FLUSH  = 8'b1011_0001;
  localparam logic [7:0] C_FLHOLD = 8'b0011_1001;
  localparam logic [7:0] C_HALT   = 8'b0010_0110;
  localparam logic [7:0] C_BUSY   = 8'b0000_1000;
  localparam logic [7:0] C_MWAIT  = 8'b0000_1011;
  localparam logic [7:0] M_NOIFID = 8'b1011_1111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", tag, got, exp);
  endtask

  task automatic check_ctl(input string tag, input logic [7:0] exp, input logic [7:0] mask = 8'hFF);
    logic [7:0] got;
    got = {hif.pc_write, hif.if_id_write, hif.id_ex_bubble, hif.if_id_flush,
           hif.pipe_hold, hif.halted, hif.state};
    check(tag, 32'(got & mask), 32'(exp & mask));
  endtask

  task automatic idle();
    hif.id_valid = 1'b0; hif.id_rs = '0; hif.id_rd = '0;
    hif.id_use_rs = 1'b0; hif.id_use_rd = 1'b0;
    hif.ex_mem_read = 1'b0; hif.ex_dest = '0;
    hif.branch_taken_ex = 1'b0; hif.halt_ex = 1'b0;
    hif.resume = 1'b0; hif.mem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic v, input logic [2:0] rs, input logic [2:0] rd,
                        input logic urs, input logic urd, input logic [2:0] dest);
    hif.id_valid = v; hif.id_rs = rs; hif.id_rd = rd;
    hif.id_use_rs = urs; hif.id_use_rd = urd;
    hif.ex_mem_read = 1'b1; hif.ex_dest = dest;
  endtask

  // Advance to just after the next rising edge; inputs are applied there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_lu(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2);
    hif.branch_taken_ex = 1'b1;
    hif.mem_busy = 1'b1;
    #3 check_ctl("reset_forced", C_RUN);
    tick(); reset = 1'b0; idle(); #1 check_ctl("run_idle", C_RUN);

    // Load-use stalls and non-hazards
    tick(); set_lu(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2); #1 check_ctl("lu_rs", C_STALL);
    tick(); idle(); #1 check_ctl("lu_release", C_RUN);
    tick(); set_lu(1'b1, 3'd1, 3'd5, 1'b0, 1'b1, 3'd5); #1 check_ctl("lu_rd", C_STALL);
    tick(); set_lu(1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 3'd3); #1 check_ctl("lu_no_match", C_RUN);
    tick(); set_lu(1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 3'd2); #1 check_ctl("lu_no_use", C_RUN);
    tick(); set_lu(1'b0, 3'd2, 3'd2, 1'b1, 1'b1, 3'd2); #1 check_ctl("lu_invalid", C_RUN);

    // Branch with simultaneous load-use: flush wins, two flush cycles
    tick(); set_lu(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 3'd4); hif.branch_taken_ex = 1'b1;
    #1 check_ctl("branch_lu", C_BRANCH, M_NOIFID);
    tick(); hif.branch_taken_ex = 1'b0; hif.halt_ex = 1'b1;
    #1 check_ctl("flush_2nd", C_FLUSH, M_NOIFID);
    tick(); idle(); #1 check_ctl("flush_done", C_RUN);

    // Halt for 10 cycles with other inputs ignored, then resume
    tick(); hif.halt_ex = 1'b1; #1 check_ctl("halt_ex", C_STALL);
    for (int i = 0; i < 10; i++) begin
      tick(); idle();
      hif.branch_taken_ex = i[0]; hif.mem_busy = i[1]; hif.halt_ex = i[2];
      if (i[0]) set_lu(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 3'd6);
      #1 check_ctl($sformatf("halt_%0d", i), C_HALT);
    end
    tick(); idle(); hif.resume = 1'b1; #1 check_ctl("resume_cycle", C_HALT);
    tick(); idle(); #1 check_ctl("after_resume", C_RUN);

    // Memory busy for 3 cycles from RUN
    tick(); hif.mem_busy = 1'b1; #1 check_ctl("busy_1", C_BUSY);
    tick(); #1 check_ctl("busy_2", C_MWAIT);
    tick(); #1 check_ctl("busy_3", C_MWAIT);
    tick(); hif.mem_busy = 1'b0;
    tick(); #1 check_ctl("busy_done", C_RUN);

    // Memory busy mid-flush freezes the counter
    tick(); hif.branch_taken_ex = 1'b1; #1 check_ctl("mf_branch", C_BRANCH, M_NOIFID);
    tick(); idle(); hif.mem_busy = 1'b1; #1 check_ctl("mf_hold_1", C_FLHOLD, M_NOIFID);
    tick(); #1 check_ctl("mf_hold_2", C_FLHOLD, M_NOIFID);
    tick(); hif.mem_busy = 1'b0; #1 check_ctl("mf_resume", C_FLUSH, M_NOIFID);
    tick(); #1 check_ctl("mf_done", C_RUN);

    // Reset in the middle of FLUSH
    tick(); hif.branch_taken_ex = 1'b1; #1 check_ctl("rf_branch", C_BRANCH, M_NOIFID);
    tick(); idle(); #1 check_ctl("rf_in_flush", C_FLUSH, M_NOIFID);
    reset = 1'b1; #1 check_ctl("rf_reset", C_RUN);
    tick(); reset = 1'b0; #1 check_ctl("rf_after", C_RUN);
    tick(); set_lu(1'b1, 3'd7, 3'd0, 1'b1, 1'b0, 3'd7); #1 check_ctl("rf_lu", C_STALL);
    tick(); idle(); #1 check_ctl("rf_lu_rel", C_RUN);

`ifdef HAZARD_PERF_CNT_EN
    // Counters: reset, 2 stalls + 1 branch, then saturation at 3
    tick(); reset = 1'b1; #1;
    tick(); reset = 1'b0; #1;
    check("cnt_reset_lu", 32'(hif.lu_stall_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); set_lu(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3);
      tick(); idle();
    end
    tick(); hif.branch_taken_ex = 1'b1;
    tick(); idle();
    tick(); #1;
    check("cnt_lu_2", 32'(hif.lu_stall_cnt), 32'd2);
    check("cnt_flush_2", 32'(hif.flush_cnt), 32'd2);
    check("cnt_mw_0", 32'(hif.mem_wait_cnt), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick(); set_lu(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3);
      tick(); idle();
    end
    tick(); hif.mem_busy = 1'b1;
    repeat (3) tick();
    hif.mem_busy = 1'b0;
    tick(); #1;
    check("cnt_lu_sat", 32'(hif.lu_stall_cnt), 32'd3);
    check("cnt_mw_sat", 32'(hif.mem_wait_cnt), 32'd3);
    check("cnt_flush_keep", 32'(hif.flush_cnt), 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
